// File: rtl/rocketcpu_audio_pkg.sv
// Shared constants, address-kind encoding and byte-merge helper for the audio register bank.
package rocketcpu_audio_pkg;

   localparam logic [31:0] DEF_RO_OFFSET   = 32'h0001_0000;
   localparam logic [31:0] DEF_CTRL_OFFSET = 32'h0000_8000;

   localparam int CTRL_COMMIT    = 0;
   localparam int CTRL_IMMEDIATE = 1;

   typedef enum logic [1:0] {
      KIND_UNMAPPED = 2'd0,
      KIND_RW       = 2'd1,
      KIND_RO       = 2'd2,
      KIND_CTRL     = 2'd3
   } kind_e;

   function automatic logic [31:0] merge(input logic [31:0] old_v,
                                         input logic [31:0] dat,
                                         input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int k = 0; k < 4; k++) begin
         if (sel[k]) r[8*k +: 8] = dat[8*k +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/rocketcpu_wb_slave_if.sv
// Wishbone accept/ack handshake and address classification for the audio register bank.
module rocketcpu_wb_slave_if
   import rocketcpu_audio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          N_RW        = 16,
   parameter int          N_RO        = 4,
   parameter logic [31:0] RO_OFFSET   = DEF_RO_OFFSET,
   parameter logic [31:0] CTRL_OFFSET = DEF_CTRL_OFFSET
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_adr,
   input  logic        i_cyc,
   output logic        o_accept,
   output logic        o_ack,
   output logic [1:0]  o_kind,
   output logic [5:0]  o_idx
);

   localparam logic [31:0] RW_SPAN   = 32'(4 * N_RW);
   localparam logic [31:0] RO_SPAN   = 32'(4 * N_RO);
   localparam logic [31:0] RO_BASE   = BASE_ADDR + RO_OFFSET;
   localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFFSET;

   logic        ack_q;
   logic [31:0] off_rw;
   logic [31:0] off_ro;

   // The ack blocks a second accept, so a held cyc yields one access per two cycles.
   assign o_accept = i_cyc & ~ack_q;
   assign o_ack    = ack_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ack_q <= 1'b0;
      else          ack_q <= o_accept;
   end

   // Offsets wrap modulo 2^32, so addresses below a window land far above its span.
   assign off_rw = i_adr - BASE_ADDR;
   assign off_ro = i_adr - RO_BASE;

   always_comb begin
      o_kind = KIND_UNMAPPED;
      o_idx  = 6'd0;
      if (off_rw < RW_SPAN) begin
         o_kind = KIND_RW;
         o_idx  = off_rw[7:2];
      end else if (off_ro < RO_SPAN) begin
         o_kind = KIND_RO;
         o_idx  = off_ro[7:2];
      end else if (i_adr[31:2] == CTRL_ADDR[31:2]) begin
         o_kind = KIND_CTRL;
      end
   end

endmodule

// File: rtl/rocketcpu_audio_regbank.sv
// Double-buffered Wishbone parameter bank: shadow writes become active together on a sample tick.
module rocketcpu_audio_regbank
   import rocketcpu_audio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          N_RW        = 16,
   parameter int          N_RO        = 4,
   parameter logic [31:0] RO_OFFSET   = DEF_RO_OFFSET,
   parameter logic [31:0] CTRL_OFFSET = DEF_CTRL_OFFSET
) (
   input  logic                  i_wb_clk,
   input  logic                  i_wb_rst_n,
   input  logic [31:0]           i_wb_adr,
   input  logic [31:0]           i_wb_dat,
   input  logic [3:0]            i_wb_sel,
   input  logic                  i_wb_we,
   input  logic                  i_wb_cyc,
   output logic [31:0]           o_wb_rdt,
   output logic                  o_wb_ack,
   input  logic                  i_sample_tick,
   input  logic [32*N_RO-1:0]    i_iparam,
   output logic [32*N_RW-1:0]    o_param,
   output logic                  o_commit
);

   logic        accept;
   logic [1:0]  kind;
   logic [5:0]  idx;

   logic [31:0] shadow_q [N_RW];
   logic [31:0] shadow_d [N_RW];
   logic [31:0] active_q [N_RW];
   logic [31:0] active_d [N_RW];
   logic [31:0] snap_q   [N_RO];
   logic        pending_q, pending_d;
   logic        immediate_q, immediate_d;
   logic [31:0] rdt_q, rdt_d;
   logic        commit_q, commit_d;

   logic commit_fire;
   logic rw_write;
   logic ctrl_write;

   rocketcpu_wb_slave_if #(
      .BASE_ADDR  (BASE_ADDR),
      .N_RW       (N_RW),
      .N_RO       (N_RO),
      .RO_OFFSET  (RO_OFFSET),
      .CTRL_OFFSET(CTRL_OFFSET)
   ) u_if (
      .i_clk   (i_wb_clk),
      .i_rst_n (i_wb_rst_n),
      .i_adr   (i_wb_adr),
      .i_cyc   (i_wb_cyc),
      .o_accept(accept),
      .o_ack   (o_wb_ack),
      .o_kind  (kind),
      .o_idx   (idx)
   );

   assign commit_fire = i_sample_tick & pending_q;
   assign rw_write    = accept & i_wb_we & (kind == KIND_RW);
   assign ctrl_write  = accept & i_wb_we & (kind == KIND_CTRL) & i_wb_sel[0];

   always_comb begin
      shadow_d    = shadow_q;
      active_d    = active_q;
      pending_d   = pending_q;
      immediate_d = immediate_q;
      rdt_d       = rdt_q;
      commit_d    = commit_fire;

      // The commit copies the pre-write shadow; a same-cycle write only lands in shadow.
      if (commit_fire) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end

      for (int i = 0; i < N_RW; i++) begin
         if (rw_write && idx == 6'(i)) begin
            shadow_d[i] = merge(shadow_q[i], i_wb_dat, i_wb_sel);
            if (immediate_q) begin
               active_d[i] = merge(active_d[i], i_wb_dat, i_wb_sel);
               commit_d    = 1'b1;
            end
         end
      end

      // Setting pending wins over a same-cycle commit clear, deferring to the next tick.
      if (ctrl_write) begin
         if (i_wb_dat[CTRL_COMMIT]) pending_d = 1'b1;
         immediate_d = i_wb_dat[CTRL_IMMEDIATE];
      end

      if (accept) begin
         rdt_d = 32'd0;
         unique case (kind)
            KIND_RW: begin
               for (int i = 0; i < N_RW; i++) if (idx == 6'(i)) rdt_d = shadow_q[i];
            end
            KIND_RO: begin
               for (int j = 0; j < N_RO; j++) if (idx == 6'(j)) rdt_d = snap_q[j];
            end
            KIND_CTRL: rdt_d = {30'd0, immediate_q, pending_q};
            default:   rdt_d = 32'd0;
         endcase
      end
   end

   // NOTE: the register arrays are reset as well, because o_param must read 0 straight out of reset.
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         for (int i = 0; i < N_RW; i++) begin
            shadow_q[i] <= 32'd0;
            active_q[i] <= 32'd0;
         end
         for (int j = 0; j < N_RO; j++) snap_q[j] <= 32'd0;
         pending_q   <= 1'b0;
         immediate_q <= 1'b0;
         rdt_q       <= 32'd0;
         commit_q    <= 1'b0;
      end else begin
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         immediate_q <= immediate_d;
         rdt_q       <= rdt_d;
         commit_q    <= commit_d;
         if (i_sample_tick) begin
            for (int j = 0; j < N_RO; j++) snap_q[j] <= i_iparam[32*j +: 32];
         end
      end
   end

   for (genvar g = 0; g < N_RW; g++) begin : g_param
      assign o_param[32*g +: 32] = active_q[g];
   end

   assign o_wb_rdt = rdt_q;
   assign o_commit = commit_q;

endmodule

// File: tb/tb_rocketcpu_audio_regbank.sv
// Directed self-checking bench for rocketcpu_audio_regbank with hand-computed expectations.
module tb_rocketcpu_audio_regbank;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] RO   = BASE + 32'h0001_0000;
   localparam logic [31:0] CTRL = BASE + 32'h0000_8000;
   localparam int N_RW = 16;
   localparam int N_RO = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [31:0]         adr = '0;
   logic [31:0]         dat = '0;
   logic [3:0]          sel = '0;
   logic                we = 1'b0;
   logic                cyc = 1'b0;
   logic [31:0]         rdt;
   logic                ack;
   logic                tick = 1'b0;
   logic [32*N_RO-1:0]  iparam = '0;
   logic [32*N_RW-1:0]  param;
   logic                commit;

   int n_checks = 0;
   int n_errors = 0;
   int commit_cnt = 0;

   always #5 clk = ~clk;

   rocketcpu_audio_regbank #(
      .BASE_ADDR(BASE), .N_RW(N_RW), .N_RO(N_RO)
   ) dut (
      .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat),
      .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt),
      .o_wb_ack(ack), .i_sample_tick(tick), .i_iparam(iparam),
      .o_param(param), .o_commit(commit)
   );

   always @(negedge clk) if (commit) commit_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pw(input int i);
      return param[32*i +: 32];
   endfunction

   // Drives one access from a negedge, optionally with a tick in the accept cycle, and returns at the ack negedge.
   task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, input logic with_tick,
                            output logic [31:0] r, output int cycles);
      @(negedge clk);
      adr = a; we = w; dat = d; sel = s; cyc = 1'b1; tick = with_tick;
      cycles = 0;
      r = 'x;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         tick = 1'b0;
         if (ack) begin
            cycles = k;
            r = rdt;
            break;
         end
      end
      check("ack_seen", 32'(cycles != 0), 32'd1);
      cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      int c;
      wb_access(a, 1'b1, d, s, 1'b0, r, c);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] r);
      int c;
      wb_access(a, 1'b0, 32'd0, 4'hF, 1'b0, r, c);
   endtask

   task automatic pulse_tick();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      int c;
      int c0;

      #12;
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_param0", pw(0), 32'd0);
      check("reset_commit", 32'(commit), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // First read: ack after one cycle, and ack drops even with cyc held.
      @(negedge clk);
      adr = BASE; we = 1'b0; sel = 4'hF; cyc = 1'b1;
      @(negedge clk);
      check("first_ack", 32'(ack), 32'd1);
      check("first_rdt", rdt, 32'd0);
      @(negedge clk);
      check("ack_drops_cyc_high", 32'(ack), 32'd0);
      cyc = 1'b0;
      check("commit_quiet", 32'(commit_cnt), 32'd0);

      // Shadow isolation and normal commit.
      wr(BASE + 32'd12, 32'hDEAD_BEEF, 4'hF);
      rd(BASE + 32'd12, r);
      check("rw3_shadow", r, 32'hDEAD_BEEF);
      check("rw3_active_before", pw(3), 32'd0);
      wr(CTRL, 32'd1, 4'hF);
      rd(CTRL, r);
      check("ctrl_pending", r, 32'd1);
      c0 = commit_cnt;
      pulse_tick();
      @(negedge clk);
      check("commit_once", 32'(commit_cnt - c0), 32'd1);
      check("rw3_active_after", pw(3), 32'hDEAD_BEEF);
      rd(CTRL, r);
      check("ctrl_cleared", r, 32'd0);

      // Byte-lane merge.
      wr(BASE, 32'h1122_3344, 4'hF);
      wr(BASE, 32'hAABB_CCDD, 4'b0101);
      rd(BASE, r);
      check("byte_lanes", r, 32'h11BB_33DD);
      check("rw0_active_untouched", pw(0), 32'd0);

      // CTRL=1 written in a tick cycle: no commit on that tick, commit on the next.
      c0 = commit_cnt;
      wb_access(CTRL, 1'b1, 32'd1, 4'hF, 1'b1, r, c);
      @(negedge clk);
      check("ctrl_tick_no_commit", 32'(commit_cnt - c0), 32'd0);
      check("ctrl_tick_rw0", pw(0), 32'd0);
      rd(CTRL, r);
      check("ctrl_tick_pending", r, 32'd1);
      pulse_tick();
      @(negedge clk);
      check("ctrl_tick_commit", 32'(commit_cnt - c0), 32'd1);
      check("ctrl_tick_rw0_after", pw(0), 32'h11BB_33DD);

      // Shadow write coinciding with a committing tick stays pending in shadow.
      wr(CTRL, 32'd1, 4'hF);
      wb_access(BASE + 32'd8, 1'b1, 32'h0000_0022, 4'hF, 1'b1, r, c);
      check("coincide_active_old", pw(2), 32'd0);
      rd(BASE + 32'd8, r);
      check("coincide_shadow", r, 32'h0000_0022);
      wr(CTRL, 32'd1, 4'hF);
      pulse_tick();
      @(negedge clk);
      check("coincide_next_commit", pw(2), 32'h0000_0022);

      // Snapshot coherence.
      iparam[31:0] = 32'h100;
      pulse_tick();
      iparam[31:0] = 32'h200;
      rd(RO, r);
      check("snap_hold_a", r, 32'h100);
      rd(RO, r);
      check("snap_hold_b", r, 32'h100);
      pulse_tick();
      rd(RO, r);
      check("snap_update", r, 32'h200);
      iparam[31:0] = 32'h300;
      wb_access(RO, 1'b0, 32'd0, 4'hF, 1'b1, r, c);
      check("ro_read_in_tick", r, 32'h200);
      rd(RO, r);
      check("ro_after_tick", r, 32'h300);
      wr(RO, 32'hFFFF_FFFF, 4'hF);
      rd(RO, r);
      check("ro_write_ignored", r, 32'h300);

      // Immediate mode.
      wr(CTRL, 32'd2, 4'hF);
      rd(CTRL, r);
      check("ctrl_immediate", r, 32'd2);
      c0 = commit_cnt;
      wb_access(BASE + 32'd4, 1'b1, 32'h5, 4'hF, 1'b0, r, c);
      check("imm_param_in_ack", pw(1), 32'h5);
      check("imm_commit_in_ack", 32'(commit), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("imm_commit_once", 32'(commit_cnt - c0), 32'd1);

      // Unmapped access.
      wb_access(BASE + 32'h4000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, r, c);
      check("unmapped_ack_latency", 32'(c), 32'd1);
      rd(BASE + 32'h4000, r);
      check("unmapped_read", r, 32'd0);
      rd(BASE, r);
      check("unmapped_no_rw0_change", r, 32'h11BB_33DD);
      check("unmapped_param0", pw(0), 32'h11BB_33DD);

      // Reset during the ack cycle.
      @(negedge clk);
      adr = BASE; we = 1'b0; cyc = 1'b1;
      @(negedge clk);
      check("pre_reset_ack", 32'(ack), 32'd1);
      rst_n = 1'b0;
      #1;
      check("reset_ack_drop", 32'(ack), 32'd0);
      check("reset_param1", pw(1), 32'd0);
      cyc = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
